// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined Gray<->binary converter with a per-beat direction
// select, valid/ready handshake and an optional Gray single-step checker.
// Sits between pointer synchronisers and FIFO full/empty/level logic. The
// checker flags Gray pointers that moved by more than one bit between
// consecutive G2B beats, which points to a corrupted crossing.
//
// Handshake: a beat moves on an edge where valid & ready are both high.
// in_ready = advance = ~out_valid | out_ready, combinational from the output
// side. When advance is low every stage holds. When advance is high every
// stage shifts by one, bubbles included, so latency is exactly STAGES cycles.
module gray_codec_pipe #(
  parameter int N        = 4,
  parameter int STAGES   = 1,
  parameter int CHECK_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_mode,
  output logic         out_step_err,
  input  logic         clr_err,
  output logic         err_sticky
);

  // Number of binary bits each stage resolves, MSB first.
  localparam int C = (N + STAGES - 1) / STAGES;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Per-stage registers. For a G2B beat in flight, the data word holds
  // already-resolved binary bits at the top and still-Gray bits below them.
  // The lowest resolved bit is the running XOR for the next bit down.
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_mode;
  logic [STAGES-1:0] stg_err;
  logic [N-1:0]      stg_data [STAGES];
  logic [N-1:0]      nxt_data [STAGES];

  logic         advance;
  logic         accept;
  logic         step_err_in;
  logic [N-1:0] prev_g;
  logic         have_prev;
  logic [N-1:0] diff;

  // Resolve Gray bits hi..lo into binary. Bit i+1 must already be binary.
  function automatic logic [N-1:0] g2b_slice(input logic [N-1:0] w,
                                             input int hi, input int lo);
    logic [N-1:0] r;
    r = w;
    for (int i = N - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) r[i] = r[i+1] ^ r[i];
    end
    return r;
  endfunction

  assign out_valid    = stg_valid[STAGES-1];
  assign out_mode     = stg_mode[STAGES-1];
  assign out_step_err = stg_err[STAGES-1];
  assign out_data     = stg_data[STAGES-1];
  assign advance      = ~out_valid | out_ready;
  assign in_ready     = advance;
  assign accept       = in_valid & advance;

  // Step check: more than one changed bit means x & (x-1) is non-zero.
  assign diff        = in_data ^ prev_g;
  assign step_err_in = (CHECK_EN != 0) && in_valid && !in_mode && have_prev &&
                       ((diff & (diff - ONE)) != '0);

  // Next value of every stage's data word: B2G finishes in stage 0 and is
  // carried, G2B resolves one slice of the XOR prefix chain per stage.
  always_comb begin
    for (int s = 0; s < STAGES; s++) nxt_data[s] = '0;
    if (in_mode) nxt_data[0] = in_data ^ (in_data >> 1);
    else         nxt_data[0] = g2b_slice(in_data, N - 1, N - C);
    for (int s = 1; s < STAGES; s++) begin
      if (stg_mode[s-1]) nxt_data[s] = stg_data[s-1];
      else               nxt_data[s] = g2b_slice(stg_data[s-1], N - 1 - s * C,
                                                 N - (s + 1) * C);
    end
  end

  // Pipeline registers: shift all stages together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= '0;
      stg_mode  <= '0;
      stg_err   <= '0;
      for (int s = 0; s < STAGES; s++) stg_data[s] <= '0;
    end else if (advance) begin
      stg_valid[0] <= in_valid;
      stg_mode[0]  <= in_mode;
      stg_err[0]   <= step_err_in;
      stg_data[0]  <= nxt_data[0];
      for (int s = 1; s < STAGES; s++) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_mode[s]  <= stg_mode[s-1];
        stg_err[s]   <= stg_err[s-1];
        stg_data[s]  <= nxt_data[s];
      end
    end
  end

  // Step-checker history: only accepted G2B beats update it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_g    <= '0;
      have_prev <= 1'b0;
    end else if (accept && !in_mode) begin
      prev_g    <= in_data;
      have_prev <= 1'b1;
    end
  end

  // Sticky error: set when a flagged beat leaves, set beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_step_err) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

endmodule
